// File: rtl/samp_pull_ctrl_pkg.sv
// Shared types for the I/Q sample path between the 4-deep sample FIFO and the
// reader-side pull controller.
//   SAMP_W       : width of each signed I and Q component
//   samp_t       : one complex sample (I and Q always travel together)
//   pull_state_t : occupancy of the 2-entry output skid buffer
package samp_pull_ctrl_pkg;

    localparam int SAMP_W = 24;

    typedef struct packed {
        logic signed [SAMP_W-1:0] i;
        logic signed [SAMP_W-1:0] q;
    } samp_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing buffered
        ONE   = 2'd1,   // head valid
        TWO   = 2'd2    // head and tail valid
    } pull_state_t;

endpackage

// File: rtl/samp_pull_ctrl.sv
// Reader-side controller for the 4-deep I/Q sample FIFO. Pops the FIFO's
// combinational head into a 2-entry skid buffer and presents the buffer head
// downstream with a PushOut/StopIn handshake, counting delivered samples.
//
// Ports:
//   Clk          : system clock, all state changes on posedge
//   Reset        : asynchronous, active-high reset
//   fifo_samp    : FIFO head sample, valid whenever fifo_empty=0
//   fifo_empty   : FIFO empty flag
//   fifo_PullOut : pop strobe to the FIFO (head consumed on the same edge)
//   StopIn       : downstream stall; transfer when PushOut=1 and StopIn=0
//   PushOut      : SampIOut/SampQOut valid
//   SampIOut     : I component of the buffer head
//   SampQOut     : Q component of the buffer head
//   SampCount    : completed downstream transfers, modulo 2^CNT_W
module samp_pull_ctrl #(
    parameter int SAMP_W = samp_pull_ctrl_pkg::SAMP_W,
    parameter int CNT_W  = 16
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  samp_pull_ctrl_pkg::samp_t fifo_samp,
    input  logic                      fifo_empty,
    output logic                      fifo_PullOut,
    input  logic                      StopIn,
    output logic                      PushOut,
    output logic signed [SAMP_W-1:0]  SampIOut,
    output logic signed [SAMP_W-1:0]  SampQOut,
    output logic [CNT_W-1:0]          SampCount
);

    import samp_pull_ctrl_pkg::*;

    pull_state_t state;
    samp_t       head;
    samp_t       tail;
    logic        pull;
    logic        xfer;

    // Pull depends only on registered state and the FIFO flag, so there is
    // no combinational path from StopIn back to the FIFO. The FIFO advances
    // its read pointer on every pull, so pulling while empty must never happen.
    assign pull         = !Reset && !fifo_empty && (state != TWO);
    assign fifo_PullOut = pull;

    assign PushOut  = (state != EMPTY);
    assign xfer     = PushOut && !StopIn;
    assign SampIOut = head.i;
    assign SampQOut = head.q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= EMPTY;
            head      <= '0;
            tail      <= '0;
            SampCount <= '0;
        end else begin
            if (xfer) begin
                SampCount <= SampCount + 1'b1;
            end

            case (state)
                EMPTY: begin
                    if (pull) begin
                        head  <= fifo_samp;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (pull && !xfer) begin
                        tail  <= fifo_samp;
                        state <= TWO;
                    end else if (pull && xfer) begin
                        // Steady-state streaming: the departing head is
                        // replaced by the new sample on the same edge.
                        head <= fifo_samp;
                    end else if (xfer) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    // No pull in TWO; only draining moves the tail forward.
                    if (xfer) begin
                        head  <= tail;
                        state <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: doc/samp_pull_ctrl.md
Name: samp_pull_ctrl

Overview:
- Reader-side controller for the 4-deep I/Q sample FIFO. It drains the FIFO's combinational head (fifo_samp) into a 2-entry output skid buffer.
- It presents samples downstream with a PushOut/StopIn handshake and maintains a running count of delivered samples.
- It sits between the FIFO output and the next DSP stage. It is the only driver of the FIFO's fifo_PullOut.

Parameters:
- SAMP_W, 24, width of each I and Q component; must match the Samp struct fields.
- CNT_W, 16, width of the delivered-sample counter SampCount.

Ports:
- Clk  input  1  system clock; all state changes on posedge.
- Reset  input  1  asynchronous, active-high reset.
- fifo_samp  input  Samp (2x SAMP_W)  FIFO head sample, combinationally valid whenever fifo_empty=0.
- fifo_empty  input  1  FIFO empty flag.
- fifo_PullOut  output  1  pop strobe to the FIFO; the head is consumed on the same posedge.
- StopIn  input  1  downstream stall; a transfer occurs on a posedge where PushOut=1 and StopIn=0.
- PushOut  output  1  SampIOut/SampQOut valid.
- SampIOut  output  SAMP_W  I component of the buffer head.
- SampQOut  output  SAMP_W  Q component of the buffer head.
- SampCount  output  CNT_W  number of completed downstream transfers, modulo 2^CNT_W.

Behaviour:
- Clocking and reset: single clock Clk. Reset is asynchronous and active-high; asserting it forces all state immediately.
- Reset values: state=EMPTY, head=0, tail=0, SampCount=0, PushOut=0, SampIOut=0, SampQOut=0, fifo_PullOut=0.
- Reset mid-operation: buffered samples are discarded; the FIFO pointers are reset by the same Reset.
- States: EMPTY (0 buffered), ONE (head valid), TWO (head and tail valid). Encoded as an enum in the package.
- Pull rule: fifo_PullOut = !Reset && !fifo_empty && (state != TWO).
  - Depends only on registered state and fifo_empty; no combinational path from StopIn.
  - Must never assert while fifo_empty=1, because the FIFO advances read_ptr unconditionally on pull.
- Transfer rule: xfer = PushOut && !StopIn. PushOut = (state != EMPTY).
  - SampIOut/SampQOut are driven from the head register.
  - Output data is held stable while PushOut=1 and StopIn=1.
- Transitions (pull = fifo_PullOut):
  - EMPTY, pull: head<=fifo_samp, ->ONE.
  - ONE, pull and !xfer: tail<=fifo_samp, ->TWO.
  - ONE, pull and xfer: head<=fifo_samp, stay ONE (full-throughput steady state).
  - ONE, !pull and xfer: ->EMPTY.
  - TWO, xfer: head<=tail, ->ONE. No pull occurs in TWO.
  - All other cases: hold.
- Latency: a sample present at the FIFO head with the buffer EMPTY appears on SampIOut/SampQOut with PushOut=1 one cycle after the pull edge.
- Throughput: one sample per cycle sustained while StopIn=0 and the FIFO is non-empty.
- SampCount: increments by 1 on every xfer and wraps from 2^CNT_W-1 to 0. Unsigned; no saturation.
- Data path: samples pass through unmodified, with no sign or width change. I and Q always move together as one Samp.
- Simultaneous pull and xfer in ONE: the new sample replaces head on the same edge; nothing is lost or duplicated.
- FIFO empty while the buffer is non-empty: the buffer continues to drain; PushOut deasserts only when state reaches EMPTY.
- StopIn held for many cycles: the buffer fills to TWO, then pulling stops. The FIFO fills and its full flag backpressures the writer.

Decomposition:
- Shared package: the existing Samp struct (I, Q, each SAMP_W signed), the SAMP_W constant, and the pull_state_t enum {EMPTY, ONE, TWO}.
- No sub-module is needed; the skid buffer and counter are one small always_ff plus combinational pull/push logic (~150 lines).

Test Plan:
- Reset: assert Reset mid-stream with the buffer in TWO.
  -> Immediately PushOut=0, fifo_PullOut=0, SampCount=0, outputs 0.
  -> After release with FIFO empty, all stay 0.
- Single sample: FIFO holds I=24'h000123, Q=24'hFFFEDC, StopIn=0.
  -> PullOut=1 for one cycle.
  -> Next cycle PushOut=1 with SampIOut=24'h000123, SampQOut=24'hFFFEDC.
  -> SampCount goes 0->1 on the transfer edge, then PushOut=0.
- Streaming: push 8 samples with I=k, Q=-k (k=1..8), StopIn=0.
  -> PushOut high for 8 consecutive cycles, samples in order, SampCount=8.
  -> fifo_PullOut never high while fifo_empty=1.
- Backpressure: 4 samples queued, StopIn=1 for 10 cycles, then 0.
  -> State reaches TWO after 2 pulls; PullOut=0 thereafter.
  -> Head output stays sample 1 throughout the stall.
  -> After release, samples 1..4 arrive on consecutive cycles.
- Toggling stall: StopIn alternates 1/0 each cycle over 6 samples.
  -> Exactly 6 transfers, no duplicates or drops, order preserved, SampCount=6.
- Counter wrap: CNT_W=4, deliver 17 samples.
  -> SampCount goes 15->0 on the 16th transfer and reads 1 after the 17th.
